cpu_bus_responder: RTL and testbench
====================================

Name: cpu_bus_responder

Overview:
- Bus-side target for the tiny_cpu address/data bus: sits on the far end of ADDRESS/RW/DATA_OUT and supplies DATA_IN, RDY and IRQ.
- Decodes a fixed memory map:
  - scratch RAM
  - GPIO port
  - 8-bit interval timer with interrupt
  - constant reset/IRQ vectors
- Inserts a programmable number of wait states through RDY.

Parameters:
- RAM_DEPTH, 32, bytes of scratch RAM at 0x0000; power of two, 2..256.
- WAIT_STATES, 1, RDY-low cycles inserted per access; 0..15.
- RESET_VECTOR, 16'h0000, value returned at 0xFFFC (low byte) and 0xFFFD (high byte).
- IRQ_VECTOR, 16'h0000, value returned at 0xFFFE (low byte) and 0xFFFF (high byte).
- OPEN_BUS, 8'hEA, read value for unmapped addresses.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-high reset.
- ADDRESS  input  16  CPU address.
- RW  input  1  1 = read, 0 = write.
- WR_DATA  input  8  CPU write data (CPU DATA_OUT).
- RD_DATA  output  8  read data to CPU (CPU DATA_IN).
- RDY  output  1  1 = access completes this cycle / CPU may proceed.
- IRQ  output  1  active-high level interrupt request.
- GPIO_IN  input  8  asynchronous external inputs.
- GPIO_OUT  output  8  output port register.

Behaviour:
- Reset:
  - One clock is the only clock; reset is synchronous and active-high.
  - Outputs after reset: RD_DATA=0, RDY=1, IRQ=0, GPIO_OUT=0, state=IDLE.
  - Timer count, reload and control registers = 0.
  - RAM contents are not reset.
  - RST during WAIT abandons the access; a pending write is not committed.
- Memory map:
  - 0x0000..RAM_DEPTH-1: RAM, read/write.
  - 0xFF00: GPIO_OUT, read/write.
  - 0xFF01: synchronized GPIO_IN, read-only.
  - 0xFF02: timer reload, read/write.
  - 0xFF03: timer control/status. bit0 EN, bit1 IE, bit7 EXP; other bits read 0. Writing bit7=1 clears EXP.
  - 0xFFFC..0xFFFF: vectors, read-only.
  - Everything else: reads return OPEN_BUS; writes are ignored. Writes to read-only locations are also ignored.
- Access FSM (IDLE, WAIT):
  - IDLE: each rising edge latches ADDRESS, RW and WR_DATA.
    - WAIT_STATES=0: the access completes at that edge; stay in IDLE.
    - Otherwise: go to WAIT with cnt=WAIT_STATES-1.
  - WAIT: RDY=0. The CPU holds the bus, but latched values are used.
    - cnt>0: decrement.
    - cnt==0: complete at this edge, go to IDLE.
  - RDY is combinational: RDY = (state==IDLE).
- Completion edge:
  - Writes commit.
  - For reads, RD_DATA is registered with the addressed value. RD_DATA holds until the next completed read.
  - Read latency = WAIT_STATES+1 edges from address presentation.
  - Back-to-back accesses are allowed; IDLE after WAIT immediately accepts the next address.
- GPIO_IN: 2-flop synchronizer; reads return the second stage.
- Timer:
  - 8-bit down counter; decrements every clock while EN=1.
  - At count==0 with EN=1: reload from the reload register and set EXP.
  - EN 0->1 write: count loads from reload (the written reload value if written the same cycle is not possible, since the registers are distinct).
  - Reload written while running: takes effect at the next reload.
  - EN=0: count frozen.
  - Reload=0 with EN=1: EXP sets every cycle.
- Simultaneous EXP set and clear-write in the same cycle: set wins.
- IRQ = EXP & IE, registered one cycle after EXP updates.

Test Plan:
- Reset, WAIT_STATES=1: write 0x5A to 0x0003, then read 0x0003. Expect RDY low exactly 1 cycle per access and RD_DATA=0x5A 2 edges after the read address; GPIO_OUT stays 0.
- WAIT_STATES=0: write 0xC3 to 0xFF00, then read 0xFF00. Expect GPIO_OUT=0xC3 the cycle after the write edge, RD_DATA=0xC3, RDY constant 1.
- Read unmapped 0x8000 → RD_DATA=0xEA. Read 0xFFFC/0xFFFD with RESET_VECTOR=16'h1234 → 0x34 then 0x12.
- Timer: reload=3, write control 0x03.
  - Expect EXP set 4 clocks after enable, then every 4 clocks.
  - IRQ=1 one cycle after EXP.
  - Writing 0x83 clears EXP/IRQ, unless the write coincides with an expiry, in which case EXP stays 1.
- GPIO_IN changes to 0xA5 → a read of 0xFF01 returns 0xA5 only when ≥2 edges separate the change from the completion edge.
- Assert RST during WAIT of a write to 0x0001 (WAIT_STATES=3) → RDY=1 next cycle and the RAM byte is unchanged.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// Bus target for the tiny_cpu: scratch RAM, GPIO, an 8-bit interval timer and constant vectors.
// Wait states hold RDY low while a latched copy of the access counts down.
module cpu_bus_responder #(
  parameter int unsigned RAM_DEPTH    = 32,
  parameter int unsigned WAIT_STATES  = 1,
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] IRQ_VECTOR   = 16'h0000,
  parameter logic [7:0]  OPEN_BUS     = 8'hEA
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ADDRESS,
  input  logic        RW,
  input  logic [7:0]  WR_DATA,
  output logic [7:0]  RD_DATA,
  output logic        RDY,
  output logic        IRQ,
  input  logic [7:0]  GPIO_IN,
  output logic [7:0]  GPIO_OUT
);

  // state | meaning
  // IDLE  | RDY high; bus latched every edge, completes at once when WAIT_STATES=0
  // WAIT  | RDY low; latched access counts down, completes when cnt reaches 0

  localparam int          AW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [15:0] RAM_TOP  = 16'(RAM_DEPTH);

  localparam logic [15:0] A_GPO    = 16'hFF00;
  localparam logic [15:0] A_GPI    = 16'hFF01;
  localparam logic [15:0] A_RELOAD = 16'hFF02;
  localparam logic [15:0] A_CTRL   = 16'hFF03;
  localparam logic [15:0] A_RVL    = 16'hFFFC;
  localparam logic [15:0] A_RVH    = 16'hFFFD;
  localparam logic [15:0] A_IVL    = 16'hFFFE;
  localparam logic [15:0] A_IVH    = 16'hFFFF;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic        complete;
  logic [3:0]  cnt_q;

  logic [15:0] lat_addr_q;
  logic        lat_rw_q;
  logic [7:0]  lat_wdata_q;

  logic [15:0] acc_addr;
  logic        acc_rw;
  logic [7:0]  acc_wdata;
  logic [AW-1:0] ram_idx;
  logic        hit_ram;
  logic        wr_en;
  logic        wr_ctrl;
  logic [7:0]  rd_val;

  logic [7:0]  ram [RAM_DEPTH];
  logic [7:0]  rd_data_q;
  logic [7:0]  gpio_out_q;
  logic [7:0]  gpi_sync1_q, gpi_sync2_q;

  logic [7:0]  reload_q;
  logic [7:0]  count_q;
  logic        en_q, ie_q, exp_q, irq_q;
  logic        exp_set;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (WAIT_STATES == 0) complete = 1'b1;
        else                  state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= 4'd0;
      lat_addr_q  <= 16'd0;
      lat_rw_q    <= 1'b1;
      lat_wdata_q <= 8'd0;
    end else if (state_q == IDLE) begin
      cnt_q       <= CNT_INIT;
      lat_addr_q  <= ADDRESS;
      lat_rw_q    <= RW;
      lat_wdata_q <= WR_DATA;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // In IDLE the live bus is the access; in WAIT the CPU may move, so use the latched copy.
  assign acc_addr  = (state_q == IDLE) ? ADDRESS : lat_addr_q;
  assign acc_rw    = (state_q == IDLE) ? RW      : lat_rw_q;
  assign acc_wdata = (state_q == IDLE) ? WR_DATA : lat_wdata_q;

  assign ram_idx = acc_addr[AW-1:0];
  assign hit_ram = (acc_addr < RAM_TOP);
  assign wr_en   = complete && !acc_rw;
  assign wr_ctrl = wr_en && (acc_addr == A_CTRL);

  always_comb begin
    rd_val = OPEN_BUS;
    if (hit_ram) begin
      rd_val = ram[ram_idx];
    end else begin
      case (acc_addr)
        A_GPO:    rd_val = gpio_out_q;
        A_GPI:    rd_val = gpi_sync2_q;
        A_RELOAD: rd_val = reload_q;
        A_CTRL:   rd_val = {exp_q, 5'd0, ie_q, en_q};
        A_RVL:    rd_val = RESET_VECTOR[7:0];
        A_RVH:    rd_val = RESET_VECTOR[15:8];
        A_IVL:    rd_val = IRQ_VECTOR[7:0];
        A_IVH:    rd_val = IRQ_VECTOR[15:8];
        default:  rd_val = OPEN_BUS;
      endcase
    end
  end

  // RAM contents survive reset; a reset edge still blocks the commit.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en && hit_ram) ram[ram_idx] <= acc_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_q   <= 8'd0;
      gpio_out_q  <= 8'd0;
      reload_q    <= 8'd0;
      gpi_sync1_q <= 8'd0;
      gpi_sync2_q <= 8'd0;
    end else begin
      gpi_sync1_q <= GPIO_IN;
      gpi_sync2_q <= gpi_sync1_q;
      if (complete && acc_rw)                    rd_data_q  <= rd_val;
      if (wr_en && (acc_addr == A_GPO))    gpio_out_q <= acc_wdata;
      if (wr_en && (acc_addr == A_RELOAD)) reload_q   <= acc_wdata;
    end
  end

  assign exp_set = en_q && (count_q == 8'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= 8'd0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_ctrl && acc_wdata[0] && !en_q) count_q <= reload_q;
      else if (en_q)                        count_q <= (count_q == 8'd0) ? reload_q : count_q - 8'd1;

      if (wr_ctrl) begin
        en_q <= acc_wdata[0];
        ie_q <= acc_wdata[1];
      end

      // An expiry on the same edge as a clear-write leaves EXP set.
      if (exp_set)                      exp_q <= 1'b1;
      else if (wr_ctrl && acc_wdata[7]) exp_q <= 1'b0;

      irq_q <= exp_q && ie_q;
    end
  end

  assign RDY      = (state_q == IDLE);
  assign RD_DATA  = rd_data_q;
  assign IRQ      = irq_q;
  assign GPIO_OUT = gpio_out_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: three instances cover WAIT_STATES of 1, 0 and 3.
module tb_cpu_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        rst_ab, rst_c;

  logic [15:0] a_addr, b_addr, c_addr;
  logic        a_rw, b_rw, c_rw;
  logic [7:0]  a_wd, b_wd, c_wd;
  logic [7:0]  a_rd, b_rd, c_rd;
  logic        a_rdy, b_rdy, c_rdy;
  logic        a_irq, b_irq, c_irq;
  logic [7:0]  a_gin, b_gin, c_gin;
  logic [7:0]  a_gout, b_gout, c_gout;

  cpu_bus_responder #(.WAIT_STATES(1), .RESET_VECTOR(16'h1234)) dut_a (
    .CLK(clk), .RST(rst_ab), .ADDRESS(a_addr), .RW(a_rw), .WR_DATA(a_wd),
    .RD_DATA(a_rd), .RDY(a_rdy), .IRQ(a_irq), .GPIO_IN(a_gin), .GPIO_OUT(a_gout));

  cpu_bus_responder #(.WAIT_STATES(0)) dut_b (
    .CLK(clk), .RST(rst_ab), .ADDRESS(b_addr), .RW(b_rw), .WR_DATA(b_wd),
    .RD_DATA(b_rd), .RDY(b_rdy), .IRQ(b_irq), .GPIO_IN(b_gin), .GPIO_OUT(b_gout));

  cpu_bus_responder #(.WAIT_STATES(3)) dut_c (
    .CLK(clk), .RST(rst_c), .ADDRESS(c_addr), .RW(c_rw), .WR_DATA(c_wd),
    .RD_DATA(c_rd), .RDY(c_rdy), .IRQ(c_irq), .GPIO_IN(c_gin), .GPIO_OUT(c_gout));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ab = 1'b1; rst_c = 1'b1;
    a_addr = 16'h0000; a_rw = 1'b1; a_wd = 8'h00; a_gin = 8'h00;
    b_addr = 16'h0000; b_rw = 1'b1; b_wd = 8'h00; b_gin = 8'h00;
    c_addr = 16'h0000; c_rw = 1'b1; c_wd = 8'h00; c_gin = 8'h00;
    @(negedge clk);
    tick(); tick();

    chk8("rst_a_rd", a_rd, 8'h00);
    chk1("rst_a_rdy", a_rdy, 1'b1);
    chk1("rst_a_irq", a_irq, 1'b0);
    chk8("rst_a_gout", a_gout, 8'h00);
    chk1("rst_b_rdy", b_rdy, 1'b1);
    chk1("rst_c_rdy", c_rdy, 1'b1);

    // WAIT_STATES=1: write 0x5A to 0x0003, read it back
    a_addr = 16'h0003; a_rw = 1'b0; a_wd = 8'h5A; rst_ab = 1'b0;
    tick(); chk1("a_wr_rdy_low", a_rdy, 1'b0);
    tick(); chk1("a_wr_rdy_high", a_rdy, 1'b1);
    a_rw = 1'b1;
    tick(); chk1("a_rd_rdy_low", a_rdy, 1'b0);
    chk8("a_rd_hold", a_rd, 8'h00);
    tick(); chk1("a_rd_rdy_high", a_rdy, 1'b1);
    chk8("a_rd_ram3", a_rd, 8'h5A);
    chk8("a_gout_zero", a_gout, 8'h00);

    a_addr = 16'h8000; tick(); tick(); chk8("a_open_bus", a_rd, 8'hEA);
    a_addr = 16'hFFFC; tick(); tick(); chk8("a_rvec_lo", a_rd, 8'h34);
    a_addr = 16'hFFFD; tick(); tick(); chk8("a_rvec_hi", a_rd, 8'h12);
    a_addr = 16'hFFFE; tick(); tick(); chk8("a_ivec_lo", a_rd, 8'h00);
    chk1("a_irq_idle", a_irq, 1'b0);

    // WAIT_STATES=0: GPIO_OUT write/read
    b_addr = 16'hFF00; b_rw = 1'b0; b_wd = 8'hC3;
    tick(); chk8("b_gout", b_gout, 8'hC3); chk1("b_rdy_wr", b_rdy, 1'b1);
    b_rw = 1'b1;
    tick(); chk8("b_rd_gpo", b_rd, 8'hC3); chk1("b_rdy_rd", b_rdy, 1'b1);

    // GPIO_IN synchronizer depth
    b_addr = 16'hFF01;
    tick(); chk8("b_gpi_init", b_rd, 8'h00);
    b_gin = 8'hA5;
    tick(); chk8("b_gpi_1edge", b_rd, 8'h00);
    tick(); chk8("b_gpi_2edge", b_rd, 8'h00);
    tick(); chk8("b_gpi_3edge", b_rd, 8'hA5);

    // Timer: reload=3, enable with IE; expiries at E4, E8, E12 after the enable edge E0
    b_addr = 16'hFF02; b_rw = 1'b0; b_wd = 8'h03; tick();
    b_addr = 16'hFF03; b_wd = 8'h03; tick();
    b_rw = 1'b1;
    tick(); tick(); tick();
    chk1("b_irq_e3", b_irq, 1'b0);
    tick(); chk8("b_ctrl_e4", b_rd, 8'h03); chk1("b_irq_e4", b_irq, 1'b0);
    tick(); chk8("b_ctrl_e5", b_rd, 8'h83); chk1("b_irq_e5", b_irq, 1'b1);
    b_rw = 1'b0; b_wd = 8'h83;
    tick(); chk1("b_irq_e6", b_irq, 1'b1);
    b_rw = 1'b1;
    tick(); chk8("b_ctrl_e7", b_rd, 8'h03); chk1("b_irq_e7", b_irq, 1'b0);
    tick(); chk8("b_ctrl_e8", b_rd, 8'h03); chk1("b_irq_e8", b_irq, 1'b0);
    tick(); chk8("b_ctrl_e9", b_rd, 8'h83); chk1("b_irq_e9", b_irq, 1'b1);
    tick(); tick();
    b_rw = 1'b0; b_wd = 8'h83;
    tick();
    b_rw = 1'b1;
    tick(); chk8("b_ctrl_setwins", b_rd, 8'h83); chk1("b_irq_setwins", b_irq, 1'b1);

    // WAIT_STATES=3: commit 0x11 to 0x0001, then reset mid-WAIT of a 0x77 write
    c_addr = 16'h0001; c_rw = 1'b0; c_wd = 8'h11; rst_c = 1'b0;
    tick(); chk1("c_w1_rdy_e1", c_rdy, 1'b0);
    tick(); tick(); chk1("c_w1_rdy_e3", c_rdy, 1'b0);
    tick(); chk1("c_w1_rdy_e4", c_rdy, 1'b1);
    c_wd = 8'h77;
    tick(); chk1("c_w2_rdy_low", c_rdy, 1'b0);
    tick();
    rst_c = 1'b1;
    tick(); chk1("c_rst_rdy", c_rdy, 1'b1);
    rst_c = 1'b0; c_rw = 1'b1;
    tick(); chk1("c_rd_rdy_low", c_rdy, 1'b0);
    tick(); tick(); tick();
    chk1("c_rd_rdy_high", c_rdy, 1'b1);
    chk8("c_ram_kept", c_rd, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
